elm_hidden_sequencer: RTL

//  Sequences one ELM hidden-layer pass: for each hidden neuron, clears the MAC, drives the
//  mod-N input-index counter (count/count9 block) through all N_INPUT features, fires the

---
 rtl/elm_hidden_sequencer_pkg.sv | 9 +
 rtl/elm_hidden_sequencer_act_wait.sv | 20 ++
 rtl/elm_hidden_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/elm_hidden_sequencer_pkg.sv
// elm_pkg: sequencer state encoding and default ELM layer dimensions
package elm_pkg;
  typedef enum logic [2:0] {IDLE, CLR, MAC, ACT, WR, DONE} state_t;
  localparam int ELM_N_INPUT  = 9;
  localparam int ELM_N_HIDDEN = 10;
  localparam int ELM_CW       = 4;
  localparam int ELM_HW       = 4;
  localparam int ELM_ACT_LAT  = 2;
endpackage

// File: rtl/elm_hidden_sequencer_act_wait.sv
// elm_act_wait: activation-latency down-counter, expire high once LAT cycles have elapsed since load
module elm_act_wait #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expire
);
  localparam int W = LAT > 1 ? $clog2(LAT) : 1;
  logic [W-1:0] cnt;
  // load with LAT-1 so the waiting state lasts exactly LAT cycles
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else if (load) cnt <= W'(LAT - 1);
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign expire = cnt == '0;
endmodule

// File: rtl/elm_hidden_sequencer.sv
// elm_hidden_sequencer: per-neuron CLR/MAC/ACT/WR sequencing of one ELM hidden-layer pass (optional ELM_SEQ_CHECK_EN adds seq_err)
module elm_hidden_sequencer
  import elm_pkg::*;
#(
  parameter int N_INPUT  = ELM_N_INPUT,
  parameter int N_HIDDEN = ELM_N_HIDDEN,
  parameter int CW       = ELM_CW,
  parameter int HW       = ELM_HW,
  parameter int ACT_LAT  = ELM_ACT_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] count,
  input  logic          count9,
  output logic          en_counter,
  output logic          rst_counter,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          act_en,
  output logic          wr_en,
  output logic [HW-1:0] wr_addr,
  output logic          busy,
`ifdef ELM_SEQ_CHECK_EN
  output logic          seq_err,
`endif
  output logic          done
);
  state_t        state;
  logic [HW-1:0] idx;
  logic          kill;
  logic          act_load;
  logic          act_expire;
  assign kill     = abort && state != IDLE;
  assign act_load = state == MAC && count9 && !abort;
  elm_act_wait #(.LAT(ACT_LAT)) u_act_wait (
    .clk    (clk),
    .rst    (rst),
    .load   (act_load),
    .dec    (state == ACT),
    .expire (act_expire)
  );
  // main FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      en_counter  <= 1'b0;
      rst_counter <= 1'b0;
      mac_clr     <= 1'b0;
      mac_en      <= 1'b0;
      act_en      <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      rst_counter <= 1'b0;
      mac_clr     <= 1'b0;
      act_en      <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      done        <= 1'b0;
      if (kill) begin
        state       <= IDLE;
        idx         <= '0;
        rst_counter <= 1'b1;
        en_counter  <= 1'b0;
        mac_en      <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state       <= CLR;
            rst_counter <= 1'b1;
            mac_clr     <= 1'b1;
            busy        <= 1'b1;
          end
          CLR: begin
            state      <= MAC;
            en_counter <= 1'b1;
            mac_en     <= 1'b1;
          end
          MAC: if (count9) begin
            state      <= ACT;
            en_counter <= 1'b0;
            mac_en     <= 1'b0;
            act_en     <= 1'b1;
          end
          ACT: if (act_expire) begin
            state   <= WR;
            wr_en   <= 1'b1;
            wr_addr <= idx;
          end
          WR: if (idx == HW'(N_HIDDEN - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state       <= CLR;
            idx         <= idx + 1'b1;
            rst_counter <= 1'b1;
            mac_clr     <= 1'b1;
          end
          DONE: begin
            state <= IDLE;
            idx   <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
`ifdef ELM_SEQ_CHECK_EN
  logic [CW-1:0] shadow;
  // shadow of the external counter; any divergence during MAC latches seq_err until reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow  <= '0;
      seq_err <= 1'b0;
    end else begin
      if (state == CLR) shadow <= '0;
      else if (state == MAC) shadow <= shadow + 1'b1;
      if (state == MAC && (count != shadow || count9 != (shadow == CW'(N_INPUT - 1)))) seq_err <= 1'b1;
    end
  end
`endif
endmodule
